// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with built-in test patterns.
// The counter state forms stage p0. All outputs are registered once from it
// (stage p1), so hs/vs/de/data/x/y stay mutually aligned.
module video_timing_gen #(
  parameter int          H_ACTIVE    = 1920,
  parameter int          H_FP        = 88,
  parameter int          H_SYNC      = 44,
  parameter int          H_BP        = 148,
  parameter int          V_ACTIVE    = 1080,
  parameter int          V_FP        = 4,
  parameter int          V_SYNC      = 5,
  parameter int          V_BP        = 36,
  parameter logic        HS_POL      = 1'b1,
  parameter logic        VS_POL      = 1'b1,
  parameter logic [23:0] SOLID_COLOR = 24'hFF0000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [23:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start
);

  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic        go;
  logic        line_end, frame_end;
  logic [11:0] h_cnt_p0, v_cnt_p0;
  logic [11:0] bar_cnt_p0;
  logic [2:0]  bar_idx_p0;
  logic [1:0]  pat_q;
  logic [1:0]  pat_cur;
  logic        vld_p0, hs_p0, vs_p0;

  logic        hs_p1, vs_p1, vld_p1, fs_p1;
  logic [23:0] data_p1;
  logic [11:0] x_p1, y_p1;

  // Pixel colour for the selected pattern at active position (x, y).
  function automatic logic [23:0] pattern_pix(input logic [1:0]  sel,
                                              input logic [2:0]  bar,
                                              input logic [11:0] x,
                                              input logic [11:0] y);
    logic [23:0] pix;
    case (sel)
      2'd0: begin
        case (bar)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd1: pix = ((x[5:0] == 6'd0) || (y[5:0] == 6'd0) || (x == X_LAST) || (y == Y_LAST))
                  ? 24'hFFFFFF : 24'h000000;
      2'd2: pix = SOLID_COLOR;
      default: pix = {x[10:3], y[10:3], 8'h80};
    endcase
    return pix;
  endfunction

  assign line_end  = (h_cnt_p0 == H_LAST);
  assign frame_end = line_end && (v_cnt_p0 == V_LAST);
  // The first pixel of a run is produced in the same edge that latches the selection.
  assign pat_cur   = (state == IDLE) ? i_pattern_sel : pat_q;
  assign vld_p0    = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hs_p0     = (h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END);
  assign vs_p0     = (v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END);

  // Run control: enable only takes effect at frame boundaries.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      IDLE: begin
        if (i_en) begin
          state_nxt = RUN;
          go        = 1'b1;
        end
      end
      RUN: begin
        go = 1'b1;
        if (frame_end && !i_en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-frame pattern latch.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      pat_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (((state == IDLE) && i_en) || ((state == RUN) && frame_end))
        pat_q <= i_pattern_sel;
    end
  end

  // Stage p0: raster counters plus the colour-bar sub-counter.
  always_ff @(posedge pclk) begin
    if (rst || !go) begin
      h_cnt_p0   <= '0;
      v_cnt_p0   <= '0;
      bar_cnt_p0 <= '0;
      bar_idx_p0 <= '0;
    end else if (line_end) begin
      h_cnt_p0   <= '0;
      v_cnt_p0   <= frame_end ? 12'd0 : v_cnt_p0 + 12'd1;
      bar_cnt_p0 <= '0;
      bar_idx_p0 <= '0;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 12'd1;
      if (bar_cnt_p0 == BAR_LAST) begin
        bar_cnt_p0 <= '0;
        bar_idx_p0 <= bar_idx_p0 + 3'd1;
      end else begin
        bar_cnt_p0 <= bar_cnt_p0 + 12'd1;
      end
    end
  end

  // Stage p1: registered outputs, forced to idle levels outside a run.
  always_ff @(posedge pclk) begin
    if (rst || !go) begin
      hs_p1   <= ~HS_POL;
      vs_p1   <= ~VS_POL;
      vld_p1  <= 1'b0;
      fs_p1   <= 1'b0;
      data_p1 <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
    end else begin
      hs_p1   <= hs_p0 ? HS_POL : ~HS_POL;
      vs_p1   <= vs_p0 ? VS_POL : ~VS_POL;
      vld_p1  <= vld_p0;
      fs_p1   <= vld_p0 && (h_cnt_p0 == 12'd0) && (v_cnt_p0 == 12'd0);
      data_p1 <= vld_p0 ? pattern_pix(pat_cur, bar_idx_p0, h_cnt_p0, v_cnt_p0) : 24'h0;
      x_p1    <= vld_p0 ? h_cnt_p0 : 12'd0;
      y_p1    <= vld_p0 ? v_cnt_p0 : 12'd0;
    end
  end

  assign o_hs          = hs_p1;
  assign o_vs          = vs_p1;
  assign o_de          = vld_p1;
  assign o_data        = data_p1;
  assign o_x           = x_p1;
  assign o_y           = y_p1;
  assign o_frame_start = fs_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed bench for video_timing_gen on a reduced raster.
module tb_video_timing_gen;

  localparam int HA = 80, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 70, VFP = 2, VSW = 3, VBP = 4;
  localparam int TH = HA + HFP + HSW + HBP;   // 96
  localparam int TV = VA + VFP + VSW + VBP;   // 79
  localparam int FRAME = TH * TV;             // 7584
  localparam int BW = HA / 8;                 // 10

  logic        pclk = 1'b0;
  logic        rst, i_en;
  logic [1:0]  i_pattern_sel;
  logic        o_hs, o_vs, o_de, o_frame_start;
  logic [23:0] o_data;
  logic [11:0] o_x, o_y;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {int f; int x; int y; logic [23:0] d;} pt_t;
  pt_t pts[$];

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .SOLID_COLOR(24'hFF0000)
  ) dut (
    .pclk(pclk), .rst(rst), .i_en(i_en), .i_pattern_sel(i_pattern_sel),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_data(o_data),
    .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start)
  );

  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [23:0] exp_pix(input int pat, input int x, input int y);
    logic [11:0] xv, yv;
    xv = 12'(x);
    yv = 12'(y);
    case (pat)
      0: case (x / BW)
           0: return 24'hFFFFFF;
           1: return 24'hFFFF00;
           2: return 24'h00FFFF;
           3: return 24'h00FF00;
           4: return 24'hFF00FF;
           5: return 24'hFF0000;
           6: return 24'h0000FF;
           default: return 24'h000000;
         endcase
      1: return ((x % 64 == 0) || (y % 64 == 0) || (x == HA - 1) || (y == VA - 1))
                ? 24'hFFFFFF : 24'h000000;
      2: return 24'hFF0000;
      default: return {xv[10:3], yv[10:3], 8'h80};
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, " de"}, 32'(o_de), 32'd0);
    check_val({tag, " hs"}, 32'(o_hs), 32'd0);
    check_val({tag, " vs"}, 32'(o_vs), 32'd0);
    check_val({tag, " fs"}, 32'(o_frame_start), 32'd0);
    check_val({tag, " data"}, 32'(o_data), 32'd0);
  endtask

  task automatic check_origin(input string tag, input logic [23:0] d);
    check_val({tag, " de"}, 32'(o_de), 32'd1);
    check_val({tag, " fs"}, 32'(o_frame_start), 32'd1);
    check_val({tag, " x"}, 32'(o_x), 32'd0);
    check_val({tag, " y"}, 32'(o_y), 32'd0);
    check_val({tag, " data"}, 32'(o_data), 32'(d));
  endtask

  // Walk one whole frame starting with the sample of pixel (0,0).
  task automatic run_frame(input int f, input int pat, input int chg_c,
                           input logic [1:0] new_sel, input logic new_en);
    int bad_t, bad_d, de_l0, hs_l0, hs_rise, de_rise2, vs_hi, vs_rise, bursts, fs_n;
    logic pde, phs, pvs;
    bad_t = 0; bad_d = 0; de_l0 = 0; hs_l0 = 0; hs_rise = -1; de_rise2 = -1;
    vs_hi = 0; vs_rise = -1; bursts = 0; fs_n = 0;
    pde = 1'b0; phs = 1'b0; pvs = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      int x, y;
      logic act, ehs, evs;
      logic [23:0] ed;
      x = c % TH;
      y = c / TH;
      act = (x < HA) && (y < VA);
      ehs = (x >= HA + HFP) && (x < HA + HFP + HSW);
      evs = (y >= VA + VFP) && (y < VA + VFP + VSW);
      ed  = act ? exp_pix(pat, x, y) : 24'h0;
      if (o_de !== act || o_hs !== ehs || o_vs !== evs ||
          o_x !== (act ? 12'(x) : 12'd0) || o_y !== (act ? 12'(y) : 12'd0) ||
          o_frame_start !== (c == 0)) bad_t++;
      if (o_data !== ed) bad_d++;
      if (c < TH && o_de) de_l0++;
      if (c < TH && o_hs) hs_l0++;
      if (o_hs && !phs && hs_rise < 0) hs_rise = c;
      if (o_de && !pde) begin
        bursts++;
        if (c > 0 && de_rise2 < 0) de_rise2 = c;
      end
      if (o_vs) vs_hi++;
      if (o_vs && !pvs && vs_rise < 0) vs_rise = c;
      if (o_frame_start) fs_n++;
      pde = o_de; phs = o_hs; pvs = o_vs;
      foreach (pts[i])
        if (pts[i].f == f && pts[i].x == x && pts[i].y == y)
          check_val($sformatf("f%0d pix(%0d,%0d)", f, x, y), 32'(o_data), 32'(pts[i].d));
      if (c == chg_c) begin
        i_pattern_sel = new_sel;
        i_en = new_en;
      end
      tick();
    end
    check_val($sformatf("f%0d timing errs", f), 32'(bad_t), 32'd0);
    check_val($sformatf("f%0d data errs", f), 32'(bad_d), 32'd0);
    check_val($sformatf("f%0d de per line", f), 32'(de_l0), 32'(HA));
    check_val($sformatf("f%0d hs width", f), 32'(hs_l0), 32'(HSW));
    check_val($sformatf("f%0d hs rise", f), 32'(hs_rise), 32'(HA + HFP));
    check_val($sformatf("f%0d line period", f), 32'(de_rise2), 32'(TH));
    check_val($sformatf("f%0d vs width", f), 32'(vs_hi), 32'(VSW * TH));
    check_val($sformatf("f%0d vs rise", f), 32'(vs_rise), 32'((VA + VFP) * TH));
    check_val($sformatf("f%0d de bursts", f), 32'(bursts), 32'(VA));
    check_val($sformatf("f%0d fs pulses", f), 32'(fs_n), 32'd1);
  endtask

  initial begin
    int stray;
    // Bars frame: sel moves to solid at line 50, so (10,60) must still be a bar.
    pts.push_back('{1, 0, 0, 24'hFFFFFF});
    pts.push_back('{1, 10, 0, 24'hFFFF00});
    pts.push_back('{1, 25, 3, 24'h00FFFF});
    pts.push_back('{1, 45, 1, 24'hFF00FF});
    pts.push_back('{1, 79, 0, 24'h000000});
    pts.push_back('{1, 10, 60, 24'hFFFF00});
    pts.push_back('{2, 0, 0, 24'hFF0000});
    pts.push_back('{2, 40, 20, 24'hFF0000});
    pts.push_back('{2, 85, 20, 24'h000000});
    pts.push_back('{3, 0, 0, 24'hFFFFFF});
    pts.push_back('{3, 64, 10, 24'hFFFFFF});
    pts.push_back('{3, 10, 64, 24'hFFFFFF});
    pts.push_back('{3, 79, 5, 24'hFFFFFF});
    pts.push_back('{3, 5, 69, 24'hFFFFFF});
    pts.push_back('{3, 1, 1, 24'h000000});
    pts.push_back('{3, 63, 63, 24'h000000});
    pts.push_back('{4, 72, 66, 24'h090880});
    pts.push_back('{4, 8, 8, 24'h010180});
    pts.push_back('{4, 0, 0, 24'h000080});

    rst = 1'b1; i_en = 1'b1; i_pattern_sel = 2'd0;
    tick(); tick();
    check_idle("reset");
    check_val("reset x", 32'(o_x), 32'd0);
    check_val("reset y", 32'(o_y), 32'd0);

    rst = 1'b0;
    tick();
    check_origin("first edge", 24'hFFFFFF);
    run_frame(1, 0, 50 * TH, 2'd2, 1'b1);
    run_frame(2, 2, 1, 2'd1, 1'b1);
    run_frame(3, 1, 1, 2'd3, 1'b1);
    run_frame(4, 3, 30 * TH, 2'd3, 1'b0);

    check_idle("after disable");
    stray = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (o_de || o_hs || o_vs || o_frame_start || o_data != 24'h0) stray++;
    end
    check_val("idle stray activity", 32'(stray), 32'd0);

    i_en = 1'b1; i_pattern_sel = 2'd0;
    tick();
    check_origin("re-enable", 24'hFFFFFF);
    for (int k = 0; k < 30 * TH; k++) tick();
    check_val("line 30 y", 32'(o_y), 32'd30);
    check_val("line 30 de", 32'(o_de), 32'd1);

    rst = 1'b1;
    tick();
    check_idle("mid-frame reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    check_origin("post reset", 24'hFFFFFF);
    tick();
    check_val("post reset x1", 32'(o_x), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
